palette_loader: RTL

// Write-side initiator for the dual-clock palette/LUT RAM; owns its wr_add/wr_data/wr_req port.

---
 rtl/palette_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/palette_loader.sv
// palette_loader: write-side initiator for the palette/LUT RAM.
// Runs one LOAD (streamed) or FILL (constant) command into consecutive, wrapping RAM addresses.
module palette_loader #(
  parameter int ram_width  = 8,
  parameter int data_width = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_fill,
  input  logic [ram_width-1:0]  cmd_base,
  input  logic [ram_width:0]    cmd_count,
  input  logic [data_width-1:0] cmd_color,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [data_width-1:0] s_data,
  output logic [ram_width-1:0]  wr_add,
  output logic [data_width-1:0] wr_data,
  output logic                  wr_req,
  output logic                  busy,
  output logic                  done
);

  // state | meaning
  // IDLE  | no command; cmd_ready=1
  // LOAD  | one write per accepted stream beat
  // FILL  | one constant-colour write per cycle
  // DONE  | completion cycle: done=1, carries the final write if there is one
  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  localparam logic [ram_width:0]   full_count = {1'b1, {ram_width{1'b0}}};
  localparam logic [ram_width:0]   cnt_one    = (ram_width+1)'(1);
  localparam logic [ram_width-1:0] addr_one   = ram_width'(1);

  state_t                state, state_nxt;
  logic [ram_width-1:0]  addr, addr_nxt;
  logic [ram_width:0]    remaining, remaining_nxt;
  logic [data_width-1:0] fill_color, fill_color_nxt;
  logic [ram_width-1:0]  wr_add_nxt;
  logic [data_width-1:0] wr_data_nxt;
  logic                  wr_req_nxt;
  logic                  done_nxt;
  logic [ram_width:0]    eff_count;

  assign eff_count = (cmd_count > full_count) ? full_count : cmd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      fill_color <= '0;
      wr_add     <= '0;
      wr_data    <= '0;
      wr_req     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      remaining  <= remaining_nxt;
      fill_color <= fill_color_nxt;
      wr_add     <= wr_add_nxt;
      wr_data    <= wr_data_nxt;
      wr_req     <= wr_req_nxt;
      done       <= done_nxt;
    end
  end

  // remaining counts writes not yet issued; the write issued while it reads 1 is the last
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (eff_count == '0)
            state_nxt = DONE;
          else if (cmd_fill)
            state_nxt = (eff_count == cnt_one) ? DONE : FILL;
          else
            state_nxt = LOAD;
        end
      end
      LOAD:    if (s_valid && remaining == cnt_one) state_nxt = DONE;
      FILL:    if (remaining == cnt_one) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FILL issues its first write directly off the accepting edge
  always_comb begin
    addr_nxt       = addr;
    remaining_nxt  = remaining;
    fill_color_nxt = fill_color;
    wr_add_nxt     = wr_add;
    wr_data_nxt    = wr_data;
    wr_req_nxt     = 1'b0;
    done_nxt       = (state_nxt == DONE);
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          fill_color_nxt = cmd_color;
          if (cmd_fill && eff_count != '0) begin
            wr_req_nxt    = 1'b1;
            wr_add_nxt    = cmd_base;
            wr_data_nxt   = cmd_color;
            addr_nxt      = cmd_base + addr_one;
            remaining_nxt = eff_count - cnt_one;
          end else begin
            addr_nxt      = cmd_base;
            remaining_nxt = eff_count;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          wr_req_nxt    = 1'b1;
          wr_add_nxt    = addr;
          wr_data_nxt   = s_data;
          addr_nxt      = addr + addr_one;
          remaining_nxt = remaining - cnt_one;
        end
      end
      FILL: begin
        wr_req_nxt    = 1'b1;
        wr_add_nxt    = addr;
        wr_data_nxt   = fill_color;
        addr_nxt      = addr + addr_one;
        remaining_nxt = remaining - cnt_one;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    cmd_ready = (state == IDLE);
    s_ready   = (state == LOAD);
  end

endmodule
